// File: rtl/bridge_gate_sequencer_if.sv
// Gate-sequencer bus: interrupter/feedback inputs, bridge gate drives and status.
// HALFCYCLE_COUNT_EN adds the last_burst_halfcycles status field.
interface bridge_gate_sequencer_if;
  logic        enable;
  logic        zcs;
  logic        fault;
  logic        fault_clear;
  logic        gate1;
  logic        gate2;
  logic        gate3;
  logic        gate4;
  logic        busy;
  logic        fault_latched;
  logic        zcs_lost;
`ifdef HALFCYCLE_COUNT_EN
  logic [15:0] last_burst_halfcycles;

  modport master (output enable, zcs, fault, fault_clear,
                  input  gate1, gate2, gate3, gate4, busy, fault_latched, zcs_lost,
                         last_burst_halfcycles);
  modport slave  (input  enable, zcs, fault, fault_clear,
                  output gate1, gate2, gate3, gate4, busy, fault_latched, zcs_lost,
                         last_burst_halfcycles);
`else
  modport master (output enable, zcs, fault, fault_clear,
                  input  gate1, gate2, gate3, gate4, busy, fault_latched, zcs_lost);
  modport slave  (input  enable, zcs, fault, fault_clear,
                  output gate1, gate2, gate3, gate4, busy, fault_latched, zcs_lost);
`endif
endinterface

// File: rtl/bridge_gate_sequencer.sv
// Full-bridge gate sequencer: ZCS-switched bursts with deadtime, timeouts and fault latch.
// Optional half-cycle burst counter enabled by HALFCYCLE_COUNT_EN.
module bridge_gate_sequencer #(
  parameter int unsigned DEADTIME            = 4,
  parameter int unsigned STARTUP_HALF_PERIOD = 50,
  parameter int unsigned ZCS_TIMEOUT         = 200,
  parameter int unsigned MAX_ON_CYCLES       = 2000,
  parameter int unsigned MIN_OFF_CYCLES      = 100
) (
  input  logic                    clk,
  input  logic                    rst,
  bridge_gate_sequencer_if.slave  bus
);

  localparam logic [15:0] DEAD_L    = 16'(DEADTIME);
  localparam logic [15:0] STARTUP_L = 16'(STARTUP_HALF_PERIOD);
  localparam logic [15:0] TIMEOUT_L = 16'(ZCS_TIMEOUT);
  localparam logic [15:0] MAX_ON_L  = 16'(MAX_ON_CYCLES);
  localparam logic [15:0] MIN_OFF_L = 16'(MIN_OFF_CYCLES);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_STOP  = 3'd2,
    ST_COOL  = 3'd3,
    ST_FAULT = 3'd4
  } state_t;

  logic        en_meta_q, en_sync_q, zcs_meta_q, zcs_sync_q, zcs_dly_q;
  state_t      state_q, state_d;
  logic        gate_a_q, gate_a_d, gate_b_q, gate_b_d;
  logic        dead_q, dead_d, pair_b_q, pair_b_d, first_q, first_d;
  logic        armed_q, armed_d, busy_q, busy_d, flt_q, flt_d, lost_q, lost_d;
  logic [15:0] cnt_q, cnt_d, burst_q, burst_d;
  logic        zcs_edge_s, stop_req_s, max_on_s, limit_hit_s, end_s;
  logic [15:0] limit_s;
`ifdef HALFCYCLE_COUNT_EN
  logic [15:0] hc_q, hc_d, last_hc_q, last_hc_d;
  logic [15:0] hc_inc_s;
`endif

  assign zcs_edge_s  = zcs_sync_q ^ zcs_dly_q;
  assign max_on_s    = (burst_q >= MAX_ON_L);
  assign stop_req_s  = !en_sync_q || max_on_s;
  assign limit_s     = first_q ? STARTUP_L : TIMEOUT_L;
  assign limit_hit_s = (cnt_q >= limit_s);
`ifdef HALFCYCLE_COUNT_EN
  assign hc_inc_s    = (hc_q == 16'hFFFF) ? hc_q : hc_q + 16'd1;
`endif

  // Next-state, counters and registered-output values
  always_comb begin
    state_d  = state_q;
    gate_a_d = gate_a_q;
    gate_b_d = gate_b_q;
    dead_d   = dead_q;
    pair_b_d = pair_b_q;
    first_d  = first_q;
    lost_d   = 1'b0;
    end_s    = 1'b0;
    cnt_d    = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
    burst_d  = (burst_q == 16'hFFFF) ? burst_q : burst_q + 16'd1;
`ifdef HALFCYCLE_COUNT_EN
    hc_d      = hc_q;
    last_hc_d = last_hc_q;
`endif
    if (!en_sync_q) begin
      armed_d = 1'b1;
    end else if (max_on_s && ((state_q == ST_RUN) || (state_q == ST_STOP))) begin
      armed_d = 1'b0;
    end else begin
      armed_d = armed_q;
    end

    if (bus.fault) begin
      state_d  = ST_FAULT;
      gate_a_d = 1'b0;
      gate_b_d = 1'b0;
      dead_d   = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          gate_a_d = 1'b0;
          gate_b_d = 1'b0;
          if (en_sync_q && armed_q) begin
            state_d  = ST_RUN;
            gate_a_d = 1'b1;
            pair_b_d = 1'b0;
            dead_d   = 1'b0;
            first_d  = 1'b1;
            cnt_d    = 16'd1;
            burst_d  = 16'd1;
`ifdef HALFCYCLE_COUNT_EN
            hc_d     = 16'd1;
`endif
          end else begin
            state_d  = ST_IDLE;
          end
        end
        ST_RUN, ST_STOP: begin
          if (dead_q) begin
            // Edges during deadtime are dropped; the window always runs to completion
            if (cnt_q >= DEAD_L) begin
              dead_d   = 1'b0;
              gate_a_d = !pair_b_q;
              gate_b_d = pair_b_q;
              cnt_d    = 16'd1;
`ifdef HALFCYCLE_COUNT_EN
              hc_d     = hc_inc_s;
`endif
            end else begin
              dead_d   = 1'b1;
            end
            if ((state_q == ST_RUN) && stop_req_s) begin
              state_d = ST_STOP;
            end else begin
              state_d = state_q;
            end
          end else if (zcs_edge_s || limit_hit_s) begin
            gate_a_d = 1'b0;
            gate_b_d = 1'b0;
            cnt_d    = 16'd1;
            // Open-loop first half-cycle limit is a normal switch, later limits are a lost ZCS
            end_s    = (state_q == ST_STOP) || stop_req_s || (!zcs_edge_s && !first_q);
            if (end_s) begin
              state_d   = ST_COOL;
              lost_d    = !zcs_edge_s && !first_q;
`ifdef HALFCYCLE_COUNT_EN
              last_hc_d = hc_q;
`endif
            end else begin
              dead_d   = 1'b1;
              pair_b_d = !pair_b_q;
              first_d  = 1'b0;
            end
          end else if ((state_q == ST_RUN) && stop_req_s) begin
            state_d = ST_STOP;
          end else begin
            state_d = state_q;
          end
        end
        ST_COOL: begin
          gate_a_d = 1'b0;
          gate_b_d = 1'b0;
          if (cnt_q >= MIN_OFF_L) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_COOL;
          end
        end
        ST_FAULT: begin
          gate_a_d = 1'b0;
          gate_b_d = 1'b0;
          if (bus.fault_clear) begin
            state_d   = ST_COOL;
            cnt_d     = 16'd1;
`ifdef HALFCYCLE_COUNT_EN
            last_hc_d = hc_q;
`endif
          end else begin
            state_d   = ST_FAULT;
          end
        end
        default: begin
          state_d  = ST_IDLE;
          gate_a_d = 1'b0;
          gate_b_d = 1'b0;
          dead_d   = 1'b0;
        end
      endcase
    end

    busy_d = (state_d == ST_RUN) || (state_d == ST_STOP) || (state_d == ST_COOL);
    flt_d  = (state_d == ST_FAULT);
  end

  // Two-flop synchronizers for the asynchronous enable and ZCS inputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_meta_q  <= 1'b0;
      en_sync_q  <= 1'b0;
      zcs_meta_q <= 1'b0;
      zcs_sync_q <= 1'b0;
      zcs_dly_q  <= 1'b0;
    end else begin
      en_meta_q  <= bus.enable;
      en_sync_q  <= en_meta_q;
      zcs_meta_q <= bus.zcs;
      zcs_sync_q <= zcs_meta_q;
      zcs_dly_q  <= zcs_sync_q;
    end
  end

  // Sequencer state, counters and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      gate_a_q <= 1'b0;
      gate_b_q <= 1'b0;
      dead_q   <= 1'b0;
      pair_b_q <= 1'b0;
      first_q  <= 1'b0;
      armed_q  <= 1'b0;
      busy_q   <= 1'b0;
      flt_q    <= 1'b0;
      lost_q   <= 1'b0;
      cnt_q    <= 16'd0;
      burst_q  <= 16'd0;
`ifdef HALFCYCLE_COUNT_EN
      hc_q      <= 16'd0;
      last_hc_q <= 16'd0;
`endif
    end else begin
      state_q  <= state_d;
      gate_a_q <= gate_a_d;
      gate_b_q <= gate_b_d;
      dead_q   <= dead_d;
      pair_b_q <= pair_b_d;
      first_q  <= first_d;
      armed_q  <= armed_d;
      busy_q   <= busy_d;
      flt_q    <= flt_d;
      lost_q   <= lost_d;
      cnt_q    <= cnt_d;
      burst_q  <= burst_d;
`ifdef HALFCYCLE_COUNT_EN
      hc_q      <= hc_d;
      last_hc_q <= last_hc_d;
`endif
    end
  end

  assign bus.gate1         = gate_a_q;
  assign bus.gate4         = gate_a_q;
  assign bus.gate2         = gate_b_q;
  assign bus.gate3         = gate_b_q;
  assign bus.busy          = busy_q;
  assign bus.fault_latched = flt_q;
  assign bus.zcs_lost      = lost_q;
`ifdef HALFCYCLE_COUNT_EN
  assign bus.last_burst_halfcycles = last_hc_q;
`endif

endmodule
